pipe_ctrl: RTL and testbench

Pipeline control unit for the 5-stage MIPS core: decides per-cycle stall/bubble for the F, D, E, M and W pipeline registers. It complements the operand forwarding muxes by handling the hazards forwarding cannot resolve:
- load-use,
- branch mispredict,
- data-memory wait states,
- halt.

It also tracks memory-wait timeout, halt and fault status, and two saturating performance counters.

---
 rtl/pipe_ctrl.sv | 138 +++++++++++++
 tb/tb_pipe_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage MIPS core: per-cycle stall/bubble
// decisions for load-use, branch mispredict, data-memory wait and halt,
// plus memory-timeout/halt status and two saturating performance counters.
//
// Handshake note: this block has no valid/ready channels. Every control
// output is a same-cycle combinational function of the inputs and the
// current state; status outputs change only on a rising clock edge or on
// reset.
module pipe_ctrl #(
    parameter logic [4:0] RNONE      = 5'h1F,
    parameter int         WAIT_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_srcA,
    input  logic [4:0]  d_srcB,
    input  logic [4:0]  E_dstM,
    input  logic        E_isload,
    input  logic        e_brmiss,
    input  logic        M_memreq,
    input  logic        m_memack,
    input  logic        W_halt,
    output logic        F_stall,
    output logic        D_stall,
    output logic        E_stall,
    output logic        M_stall,
    output logic        D_bubble,
    output logic        E_bubble,
    output logic        W_bubble,
    output logic        halted,
    output logic        mem_err,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALT    = 2'd2,
        FAULT   = 2'd3
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(WAIT_LIMIT - 1);
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    state_t      state;
    logic [15:0] wait_cnt;
    logic        memwait;
    logic        load_use;
    logic        active;
    logic        apply_brmiss;

    assign dbg_state = state;
    assign memwait   = M_memreq & ~m_memack;
    assign active    = (state == RUN) || (state == MEMWAIT);

    // Load-use hazard: an RNONE destination never matches, and because the
    // destination must differ from RNONE an RNONE source cannot match either.
    assign load_use = E_isload && (E_dstM != RNONE) &&
                      (((E_dstM == d_srcA) && (d_srcA != RNONE)) ||
                       ((E_dstM == d_srcB) && (d_srcB != RNONE)));

    // Prioritised stall/bubble decode; a freeze masks mispredict and load-use
    // because the held E stage re-presents them once the freeze lifts.
    always_comb begin
        F_stall      = 1'b0;
        D_stall      = 1'b0;
        E_stall      = 1'b0;
        M_stall      = 1'b0;
        D_bubble     = 1'b0;
        E_bubble     = 1'b0;
        W_bubble     = 1'b0;
        apply_brmiss = 1'b0;
        if (reset || !active || W_halt || memwait) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            E_stall  = 1'b1;
            M_stall  = 1'b1;
            W_bubble = 1'b1;
        end else if (e_brmiss) begin
            D_bubble     = 1'b1;
            E_bubble     = 1'b1;
            apply_brmiss = 1'b1;
        end else if (load_use) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            E_bubble = 1'b1;
        end
    end

    // State machine with wait counter and registered halted/mem_err status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= 16'd0;
            halted   <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                RUN, MEMWAIT: begin
                    if (W_halt) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (memwait) begin
                        if (wait_cnt == WAIT_LAST) begin
                            state   <= FAULT;
                            mem_err <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 16'd1;
                            state    <= MEMWAIT;
                        end
                    end else begin
                        wait_cnt <= 16'd0;
                        state    <= RUN;
                    end
                end
                default: begin
                    // HALT and FAULT are left only through reset.
                end
            endcase
        end
    end

    // Saturating performance counters for stalled fetch cycles and flushes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= 16'd0;
            flush_count  <= 16'd0;
        end else begin
            if (F_stall && active && (stall_cycles != CNT_MAX))
                stall_cycles <= stall_cycles + 16'd1;
            if (apply_brmiss && (flush_count != CNT_MAX))
                flush_count <= flush_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: load-use, mispredict, memory wait, timeout,
// halt, async reset and counter saturation.
module tb_pipe_ctrl;

    localparam logic [4:0] RNONE = 5'h1F;
    localparam logic [6:0] C_NONE   = 7'b0000_000;
    localparam logic [6:0] C_FREEZE = 7'b1111_001;
    localparam logic [6:0] C_LU     = 7'b1100_010;
    localparam logic [6:0] C_BR     = 7'b0000_110;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  d_srcA, d_srcB, E_dstM;
    logic        E_isload, e_brmiss, M_memreq, m_memack, W_halt;
    logic        F_stall, D_stall, E_stall, M_stall;
    logic        D_bubble, E_bubble, W_bubble;
    logic        halted, mem_err;
    logic [15:0] stall_cycles, flush_count;
    logic [1:0]  dbg_state;
    logic [6:0]  ctrl;

    logic [15:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    assign ctrl = {F_stall, D_stall, E_stall, M_stall, D_bubble, E_bubble, W_bubble};

    pipe_ctrl #(.RNONE(RNONE), .WAIT_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM),
        .E_isload(E_isload), .e_brmiss(e_brmiss),
        .M_memreq(M_memreq), .m_memack(m_memack), .W_halt(W_halt),
        .F_stall(F_stall), .D_stall(D_stall), .E_stall(E_stall), .M_stall(M_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble), .W_bubble(W_bubble),
        .halted(halted), .mem_err(mem_err),
        .stall_cycles(stall_cycles), .flush_count(flush_count),
        .dbg_state(dbg_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] sa, input logic [4:0] sb, input logic [4:0] dm,
                          input logic ld, input logic br, input logic rq, input logic ak,
                          input logic hl);
        d_srcA = sa; d_srcB = sb; E_dstM = dm; E_isload = ld;
        e_brmiss = br; M_memreq = rq; m_memack = ak; W_halt = hl;
    endtask

    // One cycle: expected control word queued with the stimulus, compared mid-cycle,
    // then the clock edge is taken and the bench resumes 1 time unit after it.
    task automatic cycle(input string tag, input logic [6:0] exp_ctrl);
        exp_q.push_back({9'd0, exp_ctrl});
        @(negedge clk);
        check(tag, {9'd0, ctrl}, exp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctrl", {9'd0, ctrl}, {9'd0, C_FREEZE});
        check("rst_halted", {15'd0, halted}, 16'd0);
        check("rst_mem_err", {15'd0, mem_err}, 16'd0);
        check("rst_stall_cycles", stall_cycles, 16'd0);
        check("rst_flush_count", flush_count, 16'd0);
        check("rst_state", {14'd0, dbg_state}, 16'd0);
        reset = 1'b0;

        // Load-use
        set_in(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("lu_srcB", C_LU);
        check("lu_stall_cycles", stall_cycles, 16'd1);
        set_in(5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("lu_srcA", C_LU);
        check("lu_stall_cycles2", stall_cycles, 16'd2);
        set_in(RNONE, RNONE, RNONE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("lu_rnone", C_NONE);
        set_in(5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("lu_not_load", C_NONE);
        check("lu_stall_hold", stall_cycles, 16'd2);

        // Mispredict, alone and together with load-use
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("br", C_BR);
        check("br_flush_count", flush_count, 16'd1);
        set_in(5'd7, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("br_lu", C_BR);
        check("br_lu_flush_count", flush_count, 16'd2);
        check("br_lu_stall_cycles", stall_cycles, 16'd2);

        // Memory wait: ack with request, then 3 no-ack cycles then ack
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle("mem_same_ack", C_NONE);
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("memwait1", C_FREEZE);
        check("memwait_state", {14'd0, dbg_state}, 16'd1);
        cycle("memwait2", C_FREEZE);
        e_brmiss = 1'b1;
        cycle("memwait3_br", C_FREEZE);
        check("memwait_flush_hold", flush_count, 16'd2);
        e_brmiss = 1'b0;
        m_memack = 1'b1;
        cycle("mem_ack", C_NONE);
        check("mem_ack_state", {14'd0, dbg_state}, 16'd0);
        check("mem_ack_stall_cycles", stall_cycles, 16'd5);
        check("mem_ack_mem_err", {15'd0, mem_err}, 16'd0);

        // Timeout after WAIT_LIMIT=4 no-ack cycles
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("to_wait", C_FREEZE);
        check("to_mem_err_early", {15'd0, mem_err}, 16'd0);
        cycle("to_wait4", C_FREEZE);
        check("to_mem_err", {15'd0, mem_err}, 16'd1);
        check("to_state", {14'd0, dbg_state}, 16'd3);
        check("to_stall_cycles", stall_cycles, 16'd9);
        m_memack = 1'b1;
        cycle("fault_frozen", C_FREEZE);
        check("fault_stall_hold", stall_cycles, 16'd9);
        check("fault_mem_err_hold", {15'd0, mem_err}, 16'd1);
        #2 reset = 1'b1;
        #1;
        check("fault_rst_mem_err", {15'd0, mem_err}, 16'd0);
        check("fault_rst_state", {14'd0, dbg_state}, 16'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Halt coinciding with the would-be timeout cycle
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("hl_wait", C_FREEZE);
        W_halt = 1'b1;
        cycle("halt", C_FREEZE);
        check("halt_halted", {15'd0, halted}, 16'd1);
        check("halt_no_fault", {15'd0, mem_err}, 16'd0);
        check("halt_state", {14'd0, dbg_state}, 16'd2);
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("halt_hold", C_FREEZE);
        check("halt_hold_halted", {15'd0, halted}, 16'd1);
        check("halt_stall_cycles", stall_cycles, 16'd4);
        check("halt_flush_hold", flush_count, 16'd0);
        #2 reset = 1'b1;
        #1;
        check("halt_rst_halted", {15'd0, halted}, 16'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Saturation of stall_cycles under continuous load-use
        set_in(5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (70000) @(posedge clk);
        #1;
        check("sat_stall_cycles", stall_cycles, 16'hFFFF);
        cycle("sat_ctrl", C_LU);
        check("sat_stall_hold", stall_cycles, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
